// File: rtl/zilla_div_pkg.sv
// Shared RV32M decode constants, FSM encoding and op-class helpers for the divider issue stage.
package zilla_div_pkg;

  localparam int unsigned INSN_W = 32;

  localparam logic [INSN_W-1:0] MULDIV_DIV_MASK  = 32'hFE00_407F;
  localparam logic [INSN_W-1:0] MULDIV_DIV_MATCH = 32'h0200_4033;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // OP major opcode, MULDIV funct7, funct3 in 1xx
  function automatic logic is_legal_div(input logic [INSN_W-1:0] insn);
    return (insn & MULDIV_DIV_MASK) == MULDIV_DIV_MATCH;
  endfunction

  function automatic logic is_div(input logic [2:0] funct3);
    return (funct3 == F3_DIV) || (funct3 == F3_DIVU);
  endfunction

  function automatic logic is_rem(input logic [2:0] funct3);
    return (funct3 == F3_REM) || (funct3 == F3_REMU);
  endfunction

  function automatic logic is_signed(input logic [2:0] funct3);
    return (funct3 == F3_DIV) || (funct3 == F3_REM);
  endfunction

endpackage

// File: rtl/zilla_div_req_fifo.sv
// Synchronous request FIFO with flush; head is read combinationally from storage.
module zilla_div_req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_c;
  logic             do_pop_c;

  assign full_c    = (cnt_q == CNT_W'(DEPTH));
  assign empty_c   = (cnt_q == '0);
  assign head_c    = mem_q[rd_ptr_q];
  assign do_push_c = push_i & ~full_c;
  assign do_pop_c  = pop_i & ~empty_c;

  // Flush wins over any push or pop in the same cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push_c) begin
        mem_d[wr_ptr_q] = wr_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/zilla_div_issue.sv
// In-order issue/return stage in front of the RV32M divider; one op in flight at a time.
// Define ZILLA_DIV_FASTPATH_EN to resolve divide-by-zero and signed overflow without the divider.
module zilla_div_issue
  import zilla_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [INSN_W-1:0]     req_opcode_i,
  input  logic [DATA_WIDTH-1:0] req_dividend_i,
  input  logic [DATA_WIDTH-1:0] req_divisor_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  div_valid_o,
  output logic [INSN_W-1:0]     div_opcode_o,
  output logic [DATA_WIDTH-1:0] div_dividend_o,
  output logic [DATA_WIDTH-1:0] div_divisor_o,
  input  logic                  div_busy_i,
  input  logic                  div_valid_i,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  rsp_err_o
);

  localparam int unsigned ENTRY_W = INSN_W + 2 * DATA_WIDTH + TAG_WIDTH + 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [ENTRY_W-1:0]    wr_entry_c;
  logic [ENTRY_W-1:0]    head_c;
  logic [INSN_W-1:0]     head_opcode_c;
  logic [DATA_WIDTH-1:0] head_dividend_c;
  logic [DATA_WIDTH-1:0] head_divisor_c;
  logic [TAG_WIDTH-1:0]  head_tag_c;
  logic                  head_err_c;
  logic                  full_c;
  logic                  empty_c;
  logic                  push_c;
  logic                  pop_c;

  // Legality is decided once at enqueue so the head carries its own error flag
  assign wr_entry_c = {req_opcode_i, req_dividend_i, req_divisor_i, req_tag_i,
                       ~is_legal_div(req_opcode_i)};
  assign {head_opcode_c, head_dividend_c, head_divisor_c, head_tag_c, head_err_c} = head_c;
  assign push_c     = req_valid_i & ~full_c;

  zilla_div_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .push_i    (push_c),
    .pop_i     (pop_c),
    .wr_data_i (wr_entry_c),
    .head_c    (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

`ifdef ZILLA_DIV_FASTPATH_EN
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [2:0]            head_funct3_c;
  logic                  fast_hit_c;
  logic [DATA_WIDTH-1:0] fast_result_c;

  assign head_funct3_c = head_opcode_c[14:12];

  // RISC-V defined results for x/0 and MIN_INT/-1
  always_comb begin
    fast_hit_c    = 1'b0;
    fast_result_c = '0;
    if (head_divisor_c == '0) begin
      fast_hit_c    = 1'b1;
      fast_result_c = is_rem(head_funct3_c) ? head_dividend_c : '1;
    end else if (is_signed(head_funct3_c) && (head_dividend_c == MIN_INT) &&
                 (head_divisor_c == '1)) begin
      fast_hit_c    = 1'b1;
      fast_result_c = is_div(head_funct3_c) ? MIN_INT : '0;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    pop_c        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          if (head_err_c) begin
            state_d      = ST_RESP;
            rsp_result_d = '0;
            rsp_tag_d    = head_tag_c;
            rsp_err_d    = 1'b1;
`ifdef ZILLA_DIV_FASTPATH_EN
          end else if (fast_hit_c) begin
            state_d      = ST_RESP;
            rsp_result_d = fast_result_c;
            rsp_tag_d    = head_tag_c;
            rsp_err_d    = 1'b0;
`endif
          end else if (!div_busy_i) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (div_valid_i) begin
          state_d      = ST_RESP;
          rsp_result_d = div_result_i;
          rsp_tag_d    = head_tag_c;
          rsp_err_d    = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          pop_c   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (div_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A result landing in the flush cycle already retires the in-flight op
    if (flush_i) begin
      pop_c = 1'b0;
      unique case (state_q)
        ST_ISSUE: state_d = ST_DRAIN;
        ST_WAIT:  state_d = div_valid_i ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: state_d = state_d;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready_o    = ~full_c;
  assign div_valid_o    = (state_q == ST_ISSUE);
  assign div_opcode_o   = head_opcode_c;
  assign div_dividend_o = head_dividend_c;
  assign div_divisor_o  = head_divisor_c;
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign rsp_result_o   = rsp_result_q;
  assign rsp_tag_o      = rsp_tag_q;
  assign rsp_err_o      = rsp_err_q;

endmodule

// File: tb/tb_zilla_div_issue.sv
// Directed bench for zilla_div_issue with a behavioural RV32M divider on the downstream side.
module tb_zilla_div_issue;

  localparam logic [31:0] OP_DIV  = 32'h0200_4033;
  localparam logic [31:0] OP_DIVU = 32'h0200_5033;
  localparam logic [31:0] OP_REM  = 32'h0200_6033;
  localparam logic [31:0] OP_REMU = 32'h0200_7033;
`ifdef ZILLA_DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [31:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp_res;
    logic        exp_err;
    logic        special;
  } vec_t;

  logic        clk_i;
  logic        rst_i, flush_i;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_opcode_i, req_dividend_i, req_divisor_i;
  logic [4:0]  req_tag_i;
  logic        div_valid_o;
  logic [31:0] div_opcode_o, div_dividend_o, div_divisor_o;
  logic        div_busy_i, div_valid_i;
  logic [31:0] div_result_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_tag_o;
  logic        rsp_err_o;

  logic        force_busy, man_valid, model_busy, model_valid, model_en;
  logic [31:0] man_result, model_result;
  int          model_lat;
  int          issue_cnt;
  int          total, bad;
  vec_t        vecs [11];

  assign div_busy_i   = force_busy | model_busy;
  assign div_valid_i  = man_valid | model_valid;
  assign div_result_i = man_valid ? man_result : model_result;

  zilla_div_issue dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_opcode_i   (req_opcode_i),
    .req_dividend_i (req_dividend_i),
    .req_divisor_i  (req_divisor_i),
    .req_tag_i      (req_tag_i),
    .div_valid_o    (div_valid_o),
    .div_opcode_o   (div_opcode_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_busy_i     (div_busy_i),
    .div_valid_i    (div_valid_i),
    .div_result_i   (div_result_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_tag_o      (rsp_tag_o),
    .rsp_err_o      (rsp_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (div_valid_o) issue_cnt = issue_cnt + 1;

  function automatic logic [31:0] ref_div(input logic [31:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [2:0]         f3;
    logic               ovf;
    sa  = a;
    sb  = b;
    f3  = op[14:12];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Downstream divider: latches operands on the issue pulse, answers model_lat cycles later
  initial begin : divider_model
    logic [31:0] op, a, b;
    model_busy   = 1'b0;
    model_valid  = 1'b0;
    model_result = '0;
    forever begin
      @(negedge clk_i);
      if (model_en && div_valid_o) begin
        op         = div_opcode_o;
        a          = div_dividend_o;
        b          = div_divisor_o;
        model_busy = 1'b1;
        repeat (model_lat) @(negedge clk_i);
        model_result = ref_div(op, a, b);
        model_valid  = 1'b1;
        @(negedge clk_i);
        model_valid = 1'b0;
        model_busy  = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    int n;
    n = 0;
    @(negedge clk_i);
    req_valid_i    = 1'b1;
    req_opcode_i   = op;
    req_dividend_i = a;
    req_divisor_i  = b;
    req_tag_i      = tag;
    while (!req_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL push_timeout: ready=%0b want 1", req_ready_o);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!rsp_valid_o && n < 300);
    if (rsp_valid_o) ok = 1'b1;
    else begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s_timeout: rsp_valid=0 want 1", name);
    end
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] res, input logic [4:0] tag,
                            input logic err);
    bit ok;
    wait_rsp(name, ok);
    if (ok) begin
      check({name, "_res"}, rsp_result_o, res);
      check({name, "_tag"}, 32'(rsp_tag_o), 32'(tag));
      check({name, "_err"}, 32'(rsp_err_o), 32'(err));
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin : main
    int  c0, n, exp_iss;
    bit  ok;
    total = 0; bad = 0; issue_cnt = 0;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0;
    req_opcode_i = '0; req_dividend_i = '0; req_divisor_i = '0; req_tag_i = '0;
    rsp_ready_i = 1'b1; force_busy = 1'b0; man_valid = 1'b0; man_result = '0;
    model_en = 1'b1; model_lat = 3;

    vecs[0]  = '{OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 1'b0};
    vecs[1]  = '{OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd1, 32'hFFFF_FFFA, 1'b0, 1'b0};
    vecs[2]  = '{OP_REM, 32'hFFFF_FFEC, 32'd3, 5'd2, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0013, 32'd5, 32'd6, 5'd7, 32'd0, 1'b1, 1'b0};
    vecs[5]  = '{32'h0200_0033, 32'd5, 32'd6, 5'd8, 32'd0, 1'b1, 1'b0};
    vecs[6]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7]  = '{OP_REMU, 32'd9, 32'd0, 5'd10, 32'd9, 1'b0, 1'b1};
    vecs[8]  = '{OP_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[9]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0, 1'b1};
    vecs[10] = '{32'h4200_5033, 32'd9, 32'd3, 5'd13, 32'd0, 1'b1, 1'b0};

    repeat (3) @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_div_valid", 32'(div_valid_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_result", rsp_result_o, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag_o), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    rst_i = 1'b0;

    // Single DIVU with 10-cycle divider: issue latency and one pulse
    model_lat = 10;
    c0 = issue_cnt;
    push(OP_DIVU, 32'd100, 32'd7, 5'd3);
    @(negedge clk_i);
    check("t1_no_early_issue", 32'(div_valid_o), 32'd0);
    @(negedge clk_i);
    check("t1_issue_latency", 32'(div_valid_o), 32'd1);
    expect_rsp("t1", 32'd14, 5'd3, 1'b0);
    check("t1_issue_count", 32'(issue_cnt - c0), 32'd1);
    model_lat = 3;

    for (int i = 0; i < 11; i++) begin
      c0 = issue_cnt;
      exp_iss = (vecs[i].exp_err || (FAST && vecs[i].special)) ? 0 : 1;
      push(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      expect_rsp($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].tag, vecs[i].exp_err);
      check($sformatf("vec%0d_issues", i), 32'(issue_cnt - c0), 32'(exp_iss));
    end

    // Fill the queue while the divider is busy, then drain in order
    force_busy = 1'b1;
    c0 = issue_cnt;
    push(OP_DIVU, 32'd50, 32'd5, 5'd1);
    push(OP_REMU, 32'd50, 32'd7, 5'd2);
    push(OP_DIV, 32'hFFFF_FFF6, 32'd2, 5'd3);
    push(OP_REM, 32'd17, 32'd5, 5'd4);
    @(negedge clk_i);
    check("t2_full", 32'(req_ready_o), 32'd0);
    req_valid_i = 1'b1; req_opcode_i = OP_DIVU; req_dividend_i = 32'd9;
    req_divisor_i = 32'd3; req_tag_i = 5'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t2_held", 32'(req_ready_o), 32'd0);
    end
    req_valid_i = 1'b0;
    check("t2_no_issue_busy", 32'(issue_cnt - c0), 32'd0);
    force_busy = 1'b0;
    expect_rsp("t2_r0", 32'd10, 5'd1, 1'b0);
    expect_rsp("t2_r1", 32'd1, 5'd2, 1'b0);
    expect_rsp("t2_r2", 32'hFFFF_FFFB, 5'd3, 1'b0);
    expect_rsp("t2_r3", 32'd2, 5'd4, 1'b0);
    push(OP_DIVU, 32'd9, 32'd3, 5'd5);
    expect_rsp("t2_r4", 32'd3, 5'd5, 1'b0);

    // Flush during WAIT: drained result discarded, next op issues afterwards
    model_en = 1'b0;
    c0 = issue_cnt;
    push(OP_DIVU, 32'd100, 32'd10, 5'd5);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!div_valid_o && n < 50);
    check("t4_issue", 32'(div_valid_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    model_en = 1'b1;
    push(OP_DIVU, 32'd81, 32'd9, 5'd6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t4_drain_no_issue", 32'(div_valid_o), 32'd0);
      check("t4_drain_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    man_result = 32'h55; man_valid = 1'b1;
    @(negedge clk_i);
    man_valid = 1'b0;
    expect_rsp("t4_next", 32'd9, 5'd6, 1'b0);
    check("t4_issue_count", 32'(issue_cnt - c0), 32'd2);

    // Back-pressure: response held stable, no second issue until pop
    rsp_ready_i = 1'b0;
    c0 = issue_cnt;
    push(OP_REMU, 32'd100, 32'd7, 5'd9);
    push(OP_DIVU, 32'd8, 32'd2, 5'd10);
    wait_rsp("t5", ok);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("t5_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("t5_hold_res", rsp_result_o, 32'd2);
      check("t5_hold_tag", 32'(rsp_tag_o), 32'd9);
    end
    check("t5_single_issue", 32'(issue_cnt - c0), 32'd1);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    expect_rsp("t5_second", 32'd4, 5'd10, 1'b0);

    // Flush while a response is pending drops it next cycle
    rsp_ready_i = 1'b0;
    push(OP_DIVU, 32'd7, 32'd7, 5'd11);
    wait_rsp("t7", ok);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("t7_rsp_dropped", 32'(rsp_valid_o), 32'd0);
    check("t7_ready", 32'(req_ready_o), 32'd1);
    rsp_ready_i = 1'b1;

    // Reset mid-op clears the queue: the op does not reissue
    model_en = 1'b0;
    push(OP_DIVU, 32'd6, 32'd3, 5'd14);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!div_valid_o && n < 50);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    c0 = issue_cnt;
    check("t8_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("t8_ready", 32'(req_ready_o), 32'd1);
    repeat (4) @(negedge clk_i);
    check("t8_no_reissue", 32'(issue_cnt - c0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
